// File: rtl/panel_lamp_driver.sv
// panel_lamp_driver: serialises the front-panel lamp image (run, 15 address
// lamps, 12 data lamps) into an external 32-bit shift/latch lamp chain.
// Optional build macro LAMP_TEST_EN adds a lamp_test input that forces an
// all-ones frame and requests a frame on its rising edge.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for refresh terminal, update, or a pending request
// LOAD     | snapshot selected data, addr and run into the frame register
// SHIFT_LO | ser_clk low, current bit presented on ser_data
// SHIFT_HI | ser_clk high, ser_data held for the chain's rising edge
// LATCH    | ser_latch pulse transfers the chain into its storage stage
module panel_lamp_driver #(
  parameter int CLK_DIV        = 2,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef LAMP_TEST_EN
  input  logic        lamp_test,
`endif
  input  logic [0:2]  dsel,
  input  logic [0:11] state_word,
  input  logic [0:11] status,
  input  logic [0:11] ac,
  input  logic [0:11] md,
  input  logic [0:11] mq,
  input  logic [0:11] bus,
  input  logic [0:14] addr,
  input  logic        run,
  input  logic        update,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic        busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);
  localparam logic [4:0]       LAST_BIT = 5'd31;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LATCH    = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DIV_W-1:0]   div_q;
  logic [4:0]         bit_q;
  logic [31:0]        frame_q;
  logic [REF_W-1:0]   refresh_q;
  logic               pending_q;
  logic [0:11]        data_sel;
  logic               refresh_tc;
  logic               div_tc;
  logic               lamp_req;
  logic               test_frame;
  logic               req;

`ifdef LAMP_TEST_EN
  logic lamp_test_q;

  // Remember the previous lamp_test level so a rising edge can request a frame.
  always_ff @(posedge clk) begin
    if (reset) lamp_test_q <= 1'b0;
    else       lamp_test_q <= lamp_test;
  end

  assign lamp_req   = lamp_test & ~lamp_test_q;
  assign test_frame = lamp_test;
`else
  assign lamp_req   = 1'b0;
  assign test_frame = 1'b0;
`endif

  assign refresh_tc = (refresh_q == REF_LAST);
  assign div_tc     = (div_q == '0);
  assign req        = update | refresh_tc | lamp_req;

  // Data-lamp source selected by the front-panel data-select switch.
  always_comb begin
    data_sel = '0;
    case (dsel)
      3'd0:    data_sel = state_word;
      3'd1:    data_sel = status;
      3'd2:    data_sel = ac;
      3'd3:    data_sel = md;
      3'd4:    data_sel = mq;
      3'd5:    data_sel = bus;
      default: data_sel = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; each shift/latch phase lasts CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req || pending_q) state_d = LOAD;
      LOAD:     state_d = SHIFT_LO;
      SHIFT_LO: if (div_tc) state_d = SHIFT_HI;
      SHIFT_HI: if (div_tc) state_d = (bit_q == LAST_BIT) ? LATCH : SHIFT_LO;
      LATCH:    if (div_tc) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Phase timer, bit index, frame shift register, refresh timer and pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      refresh_q <= REF_LAST;
      pending_q <= 1'b0;
    end else begin
      if (state_d != state_q) div_q <= DIV_LOAD;
      else if (!div_tc)       div_q <= div_q - DIV_ONE;

      if (state_q == LOAD) begin
        bit_q   <= '0;
        frame_q <= test_frame ? '1 : {4'b0000, run, addr, data_sel};
      end else if (state_q == SHIFT_HI && div_tc) begin
        // Advancing here makes ser_data change only on entry to SHIFT_LO.
        bit_q   <= bit_q + 5'd1;
        frame_q <= {frame_q[30:0], 1'b0};
      end

      // Restarting at LOAD makes REFRESH_CYCLES the start-to-start interval.
      if (state_q == IDLE && state_d == LOAD) refresh_q <= '0;
      else if (refresh_tc)                    refresh_q <= '0;
      else                                    refresh_q <= refresh_q + REF_ONE;

      // Requests arriving while busy coalesce into a single follow-up frame.
      if (state_q != IDLE && req) pending_q <= 1'b1;
      else if (state_q == LOAD)   pending_q <= 1'b0;
    end
  end

  // Outputs decoded from state so a reset returns them to zero on the next edge.
  always_comb begin
    ser_clk   = (state_q == SHIFT_HI);
    ser_latch = (state_q == LATCH);
    busy      = (state_q != IDLE);
    ser_data  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) ? frame_q[31] : 1'b0;
  end

endmodule

// File: tb/tb_panel_lamp_driver.sv
// Self-checking bench for panel_lamp_driver: a negedge monitor reassembles the
// serial frames from the lamp-chain pins, and directed steps compare them
// against frames built from the lamp-image rules and expected frame timing.
module tb_panel_lamp_driver;
  localparam int D         = 2;
  localparam int R         = 200;
  localparam int FRAME_LEN = 65 * D + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  dsel = 3'd0;
  logic [14:0] addr = 15'd0;
  logic [11:0] srcv [8];
`ifdef LAMP_TEST_EN
  logic        lamp_test = 1'b0;
`endif
  logic        ser_data, ser_clk, ser_latch, busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  panel_lamp_driver #(.CLK_DIV(D), .REFRESH_CYCLES(R)) dut (
    .clk(clk), .reset(reset),
`ifdef LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .dsel(dsel),
    .state_word(srcv[0]), .status(srcv[1]), .ac(srcv[2]),
    .md(srcv[3]), .mq(srcv[4]), .bus(srcv[5]),
    .addr(addr), .run(run), .update(update),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one record per busy period (captured word, bit count, latch length).
  logic [31:0] q_word [$];
  int q_nb [$], q_lat [$], q_len [$], q_rise [$], q_end [$], q_load [$];
  logic [31:0] m_sh = '0;
  int m_nb = 0, m_lat = 0, m_start = 0, m_rise = -1;
  logic m_pbusy = 1'b0, m_pclk = 1'b0, m_held = 1'b0;
  int unstable = 0, stray = 0;

  always @(negedge clk) begin
    if (busy && !m_pbusy) begin
      q_load.push_back(cyc);
      m_start = cyc; m_sh = '0; m_nb = 0; m_lat = 0; m_rise = -1;
    end
    if (busy) begin
      if (ser_clk && !m_pclk) begin
        m_sh = {m_sh[30:0], ser_data};
        m_nb++;
        m_held = ser_data;
        if (m_rise < 0) m_rise = cyc - m_start;
      end else if (ser_clk && ser_data !== m_held) begin
        unstable++;
      end
      if (ser_latch) begin
        m_lat++;
        if (ser_clk || ser_data) stray++;
      end
    end else if (ser_latch) begin
      stray++;
    end
    if (!busy && m_pbusy) begin
      q_word.push_back(m_sh); q_nb.push_back(m_nb); q_lat.push_back(m_lat);
      q_len.push_back(cyc - m_start); q_rise.push_back(m_rise); q_end.push_back(cyc);
    end
    m_pbusy = busy;
    m_pclk  = ser_clk;
  end

  // Reference frame: four zero pads, run, address lamps, then the selected data.
  function automatic logic [31:0] model_frame();
    logic [11:0] d;
    d = (dsel < 3'd6) ? srcv[dsel] : 12'h000;
    return {4'b0000, run, addr, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (q_word.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_timeout", 32'(q_word.size() >= n), 32'd1);
    if (q_word.size() < n) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic wait_until(input int target);
    do begin
      @(posedge clk); #1;
    end while (cyc < target);
  endtask

  task automatic pulse_update(output int n);
    @(posedge clk); #1;
    n = cyc;
    update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 6; i++) srcv[i] = 12'($urandom);
    addr = 15'($urandom);
    run  = 1'($urandom);
  endtask

  initial begin
    int k, n, rel, rises, l2, lb;
    logic pclk;
    logic [31:0] e1, e2;

    for (int i = 0; i < 8; i++) srcv[i] = 12'($urandom);
    srcv[6] = '0; srcv[7] = '0;
    dsel = 3'd2; srcv[2] = 12'o5252; addr = 15'o12345; run = 1'b1;

    // Reset, then power-on frame loads in the first cycle after release.
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", 32'({ser_data, ser_clk, ser_latch, busy}), 32'd0);
    rel = cyc;
    reset = 1'b0;
    e1 = model_frame();
    wait_frames(1, 400);
    check("poweron_load_cycle", q_load[0], rel + 1);
    check("poweron_word_literal", q_word[0], 32'h094E5AAA);
    check("poweron_word_model", q_word[0], e1);
    check("poweron_nbits", q_nb[0], 32);
    check("poweron_latch_len", q_lat[0], D);
    check("poweron_busy_len", q_len[0], FRAME_LEN);
    check("poweron_first_rise", q_rise[0], 1 + D);

    // Step the data-select switch through every position.
    for (int s = 0; s < 8; s++) begin
      randomize_inputs();
      dsel = 3'(s);
      k = q_word.size();
      pulse_update(n);
      e1 = model_frame();
      wait_frames(k + 1, 400);
      check($sformatf("dsel%0d_word", s), q_word[k], e1);
      check($sformatf("dsel%0d_load", s), q_load[k], n + 1);
      if (s == 0) check("update_first_rise", q_rise[k] + q_load[k], n + 2 + D);
    end

    // Three mid-frame requests coalesce into one follow-up frame; mid-frame
    // input changes only reach the follow-up frame.
    randomize_inputs();
    dsel = 3'd3;
    k = q_word.size();
    pulse_update(n);
    e1 = model_frame();
    wait_until(n + 20); update = 1'b1; @(posedge clk); #1; update = 1'b0;
    wait_until(n + 50); update = 1'b1; @(posedge clk); #1; update = 1'b0;
    wait_until(n + 80); update = 1'b1; @(posedge clk); #1; update = 1'b0;
    wait_until(n + 100);
    randomize_inputs();
    dsel = 3'd4;
    e2 = model_frame();
    wait_frames(k + 2, 500);
    check("pend_frame1_word", q_word[k], e1);
    check("pend_frame2_word", q_word[k + 1], e2);
    check("pend_frame2_start", q_load[k + 1], q_end[k] + 1);
    wait_until(q_end[k + 1] + 40);
    check("pend_no_third", q_word.size(), k + 2);

    // Periodic refresh with no update; an mq change mid-frame shows next frame.
    l2 = q_load[k + 1];
    k = q_word.size();
    e1 = model_frame();
    wait_until(l2 + R + 30);
    srcv[4] = ~srcv[4];
    e2 = model_frame();
    wait_frames(k + 2, 700);
    check("refresh_load_a", q_load[k], l2 + R);
    check("refresh_load_b", q_load[k + 1], l2 + 2 * R);
    check("refresh_word_a_old", q_word[k], e1);
    check("refresh_word_b_new", q_word[k + 1], e2);

    // Update coinciding with refresh terminal yields a single frame.
    lb = q_load[k + 1];
    wait_until(lb + R - 1);
    update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
    k = q_word.size();
    wait_frames(k + 2, 700);
    check("coincide_load", q_load[k], lb + R);
    check("coincide_next_refresh", q_load[k + 1], lb + 2 * R);

    // Reset at the 10th ser_clk rise abandons the frame without a latch.
    randomize_inputs();
    dsel = 3'd5;
    k = q_word.size();
    pulse_update(n);
    rises = 0;
    pclk = 1'b0;
    for (int t = 0; t < 400 && rises < 10; t++) begin
      @(negedge clk);
      if (ser_clk && !pclk) rises++;
      pclk = ser_clk;
    end
    check("rise10_seen", rises, 10);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", 32'({ser_data, ser_clk, ser_latch, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    randomize_inputs();
    dsel = 3'd1;
    e1 = model_frame();
    rel = cyc;
    reset = 1'b0;
    wait_frames(k + 2, 500);
    check("abort_nbits", q_nb[k], 10);
    check("abort_no_latch", q_lat[k], 0);
    check("after_reset_load", q_load[k + 1], rel + 1);
    check("after_reset_word", q_word[k + 1], e1);
    check("after_reset_latch", q_lat[k + 1], D);

`ifdef LAMP_TEST_EN
    // Lamp test: rising edge starts an all-ones frame; live data afterwards.
    k = q_word.size();
    @(posedge clk); #1;
    n = cyc;
    lamp_test = 1'b1;
    wait_frames(k + 1, 400);
    lamp_test = 1'b0;
    check("lamp_test_load", q_load[k], n + 1);
    check("lamp_test_word", q_word[k], 32'hFFFF_FFFF);
    e1 = model_frame();
    wait_frames(k + 2, 400);
    check("lamp_test_live_after", q_word[k + 1], e1);
`endif

    check("data_stable_while_high", unstable, 0);
    check("latch_phase_clean", stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
